// File: rtl/irled_drv_ctrl.sv
// Multi-channel IR/RGB LED driver controller: bias sequencing, soft-start/stop
// current-code ramping, half-current mode and glitch-free registered PWM.
module irled_drv_ctrl #(
  parameter int NCH        = 2,
  parameter int PWM_W      = 8,
  parameter int CUR_W      = 8,
  parameter int SETTLE_CYC = 64,
  parameter int RAMP_DIV   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   half_cur,
  input  logic [NCH-1:0]         ch_en,
  input  logic [NCH*PWM_W-1:0]   duty,
  input  logic [NCH*CUR_W-1:0]   cur_tgt,
  output logic                   bias_en,
  output logic                   ready,
  output logic [NCH-1:0]         pwm_out,
  output logic [NCH*CUR_W-1:0]   cur_code
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [RW-1:0] RAMP_LAST   = RW'(RAMP_DIV - 1);

  typedef enum logic [1:0] {OFF, SETTLE, RUN, RAMPDN} state_t;

  state_t                 state, next_state;
  logic [SW-1:0]          settle_cnt;
  logic [RW-1:0]          presc;
  logic [PWM_W-1:0]       pwm_cnt;
  logic [NCH*PWM_W-1:0]   duty_q;
  logic [NCH*CUR_W-1:0]   tgt_eff;
  logic                   ramp_active;
  logic                   ramp_tc;
  logic                   pwm_run;
  logic                   duty_load;
  logic                   all_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OFF;
    else     state <= next_state;
  end

  always_comb begin
    all_zero   = (cur_code == '0);
    next_state = state;
    case (state)
      OFF:     if (en) next_state = SETTLE;
      SETTLE:  if (!en) next_state = OFF;
               else if (settle_cnt == SETTLE_LAST) next_state = RUN;
      RUN:     if (!en) next_state = RAMPDN;
      RAMPDN:  if (en) next_state = RUN;
               else if (all_zero) next_state = OFF;
      default: next_state = OFF;
    endcase
  end

  always_comb begin
    bias_en = (state != OFF);
    ready   = (state == RUN);
  end

  // PWM is gated by the upcoming state too, so dropping en silences it on the next edge.
  always_comb begin
    ramp_active = (state == RUN) || (state == RAMPDN);
    ramp_tc     = (presc == RAMP_LAST);
    pwm_run     = (state == RUN) && (next_state == RUN);
    duty_load   = (next_state == RUN) && ((state != RUN) || (pwm_cnt == '1));
    tgt_eff     = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (state == RUN && ch_en[i])
        tgt_eff[i*CUR_W +: CUR_W] = half_cur ? (cur_tgt[i*CUR_W +: CUR_W] >> 1)
                                             : cur_tgt[i*CUR_W +: CUR_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
      presc      <= '0;
      pwm_cnt    <= '0;
      duty_q     <= '0;
      pwm_out    <= '0;
      cur_code   <= '0;
    end else begin
      settle_cnt <= (state == SETTLE && next_state == SETTLE) ? settle_cnt + 1'b1 : '0;
      presc      <= (ramp_active && next_state == state && !ramp_tc) ? presc + 1'b1 : '0;
      pwm_cnt    <= pwm_run ? pwm_cnt + 1'b1 : '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (duty_load)
          duty_q[i*PWM_W +: PWM_W] <= duty[i*PWM_W +: PWM_W];
        pwm_out[i] <= pwm_run && ch_en[i] && (pwm_cnt < duty_q[i*PWM_W +: PWM_W]);
        if (ramp_active && ramp_tc) begin
          if (cur_code[i*CUR_W +: CUR_W] < tgt_eff[i*CUR_W +: CUR_W])
            cur_code[i*CUR_W +: CUR_W] <= cur_code[i*CUR_W +: CUR_W] + 1'b1;
          else if (cur_code[i*CUR_W +: CUR_W] > tgt_eff[i*CUR_W +: CUR_W])
            cur_code[i*CUR_W +: CUR_W] <= cur_code[i*CUR_W +: CUR_W] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_irled_drv_ctrl.sv
// Self-checking bench for irled_drv_ctrl: directed scenarios plus randomized
// stimulus against a cycle-level behavioural model.
module tb_irled_drv_ctrl;

  localparam int NCH = 2, PWM_W = 4, CUR_W = 8, SETTLE_CYC = 8, RAMP_DIV = 2;
  localparam int PER = 16;
  localparam int S_OFF = 0, S_SETTLE = 1, S_RUN = 2, S_RAMPDN = 3;

  logic                 clk = 1'b0;
  logic                 rst, en, half_cur;
  logic [NCH-1:0]       ch_en;
  logic [NCH*PWM_W-1:0] duty;
  logic [NCH*CUR_W-1:0] cur_tgt;
  logic                 bias_en, ready;
  logic [NCH-1:0]       pwm_out;
  logic [NCH*CUR_W-1:0] cur_code;

  int n_checks = 0, n_fail = 0, cyc = 0, run_entry = 0;
  int m_st, m_settle, m_presc, m_cnt;
  int m_dq[NCH], m_code[NCH];
  bit m_pwm[NCH];

  irled_drv_ctrl #(.NCH(NCH), .PWM_W(PWM_W), .CUR_W(CUR_W),
                   .SETTLE_CYC(SETTLE_CYC), .RAMP_DIV(RAMP_DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .half_cur(half_cur), .ch_en(ch_en),
    .duty(duty), .cur_tgt(cur_tgt), .bias_en(bias_en), .ready(ready),
    .pwm_out(pwm_out), .cur_code(cur_code));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] dut_vec();
    return {bias_en, ready, pwm_out, cur_code};
  endfunction

  function automatic logic [19:0] exp_vec();
    return {m_st != S_OFF, m_st == S_RUN, m_pwm[1], m_pwm[0], 8'(m_code[1]), 8'(m_code[0])};
  endfunction

  function automatic int eff_tgt(int i);
    int t = 0;
    if (m_st == S_RUN && ch_en[i]) begin
      t = int'(cur_tgt[i*CUR_W +: CUR_W]);
      if (half_cur) t = t / 2;
    end
    return t;
  endfunction

  task automatic model_reset();
    m_st = S_OFF; m_settle = 0; m_presc = 0; m_cnt = 0;
    for (int i = 0; i < NCH; i++) begin m_dq[i] = 0; m_code[i] = 0; m_pwm[i] = 0; end
  endtask

  task automatic model_edge();
    int nst, t;
    bit tc, zero;
    zero = (m_code[0] == 0) && (m_code[1] == 0);
    case (m_st)
      S_OFF:    nst = en ? S_SETTLE : S_OFF;
      S_SETTLE: nst = !en ? S_OFF : ((m_settle == SETTLE_CYC - 1) ? S_RUN : S_SETTLE);
      S_RUN:    nst = en ? S_RUN : S_RAMPDN;
      default:  nst = en ? S_RUN : (zero ? S_OFF : S_RAMPDN);
    endcase
    tc = (m_st >= S_RUN) && (m_presc == RAMP_DIV - 1);
    for (int i = 0; i < NCH; i++) begin
      m_pwm[i] = (m_st == S_RUN) && (nst == S_RUN) && ch_en[i] && (m_cnt < m_dq[i]);
      if (tc) begin
        t = eff_tgt(i);
        if (m_code[i] < t) m_code[i]++;
        else if (m_code[i] > t) m_code[i]--;
      end
      if (nst == S_RUN && (m_st != S_RUN || m_cnt == PER - 1))
        m_dq[i] = int'(duty[i*PWM_W +: PWM_W]);
    end
    m_cnt    = (m_st == S_RUN && nst == S_RUN) ? (m_cnt + 1) % PER : 0;
    m_presc  = (m_st >= S_RUN && nst == m_st && !tc) ? m_presc + 1 : 0;
    m_settle = (m_st == S_SETTLE && nst == S_SETTLE) ? m_settle + 1 : 0;
    m_st     = nst;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; half_cur = 1'b0; ch_en = '0; duty = '0; cur_tgt = '0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (dut_vec() !== 20'h0) begin
      n_fail++; $display("FAIL reset_values got=%h exp=%h", dut_vec(), 20'h0);
    end
    rst = 1'b0;
  endtask

  task automatic test_startup();
    int ready_edge = -1;
    cur_tgt = {8'd4, 8'd10}; ch_en = 2'b11; duty = {4'd0, 4'd5}; en = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL startup cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (e == 1) begin
        n_checks++;
        if (bias_en !== 1'b1) begin n_fail++; $display("FAIL bias_on got=%b exp=1", bias_en); end
      end
      if (e < 9) begin
        n_checks++;
        if (cur_code !== '0) begin
          n_fail++; $display("FAIL settle_codes e=%0d got=%h exp=0", e, cur_code);
        end
      end
      if (ready === 1'b1 && ready_edge < 0) begin ready_edge = e; run_entry = cyc; end
    end
    n_checks++;
    if (ready_edge != 9) begin
      n_fail++; $display("FAIL ready_latency got=%0d exp=9", ready_edge);
    end
  endtask

  task automatic test_ramp_up();
    int t0 = -1, t1 = -1;
    for (int k = 0; k < 30; k++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL ramp_up cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (cur_code[7:0] == 8'd10 && t0 < 0) t0 = cyc - run_entry;
      if (cur_code[15:8] == 8'd4 && t1 < 0) t1 = cyc - run_entry;
    end
    n_checks++;
    if (t0 != 20) begin n_fail++; $display("FAIL ch0_reach got=%0d exp=20", t0); end
    n_checks++;
    if (t1 != 8) begin n_fail++; $display("FAIL ch1_reach got=%0d exp=8", t1); end
  endtask

  task automatic test_pwm();
    int hi0 = 0, hi1 = 0, guard = 0;
    for (int k = 0; k < 32; k++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL pwm cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      hi0 += int'(pwm_out[0]); hi1 += int'(pwm_out[1]);
    end
    n_checks++;
    if (hi0 != 10) begin n_fail++; $display("FAIL pwm_ch0_high got=%0d exp=10", hi0); end
    n_checks++;
    if (hi1 != 0) begin n_fail++; $display("FAIL pwm_ch1_low got=%0d exp=0", hi1); end
    while (m_cnt != 8 && guard < 20) begin
      tick(); guard++;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL pwm_align cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    // remaining cycles 8..15 keep duty 5 (0 high), then two periods of 12 -> 24
    duty[3:0] = 4'd12; hi0 = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL pwm_change cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      hi0 += int'(pwm_out[0]);
    end
    n_checks++;
    if (hi0 != 24) begin n_fail++; $display("FAIL pwm_duty_change got=%0d exp=24", hi0); end
  endtask

  task automatic test_half_cur();
    int lo = 255, prev, c = 0;
    bit jump = 0;
    prev = int'(cur_code[7:0]);
    half_cur = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL half_cur cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      c = int'(cur_code[7:0]);
      if (c < lo) lo = c;
      if (c > prev + 1 || c < prev - 1) jump = 1;
      prev = c;
    end
    n_checks++;
    if (lo != 5) begin n_fail++; $display("FAIL half_no_overshoot got=%0d exp=5", lo); end
    n_checks++;
    if (c != 5) begin n_fail++; $display("FAIL half_final got=%0d exp=5", c); end
    n_checks++;
    if (jump) begin n_fail++; $display("FAIL half_step got=jump exp=single_steps"); end
    half_cur = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL half_restore cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_shutdown();
    int start, t_zero = -1, t_off = -1;
    start = cyc;
    en = 1'b0;
    tick();
    n_checks++;
    if (pwm_out !== 2'b00 || ready !== 1'b0) begin
      n_fail++; $display("FAIL shutdown_pwm got=%b/%b exp=00/0", pwm_out, ready);
    end
    for (int k = 0; k < 40 && t_off < 0; k++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL shutdown cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (cur_code[7:0] == 8'd0 && t_zero < 0) t_zero = cyc;
      if (bias_en === 1'b0) t_off = cyc;
    end
    n_checks++;
    if (t_off - start != 22) begin
      n_fail++; $display("FAIL bias_off_time got=%0d exp=22", t_off - start);
    end
    n_checks++;
    if (t_off - t_zero != 1) begin
      n_fail++; $display("FAIL bias_off_after_zero got=%0d exp=1", t_off - t_zero);
    end
  endtask

  task automatic test_abort();
    int saved, lo = 255, c = 0, guard = 0;
    en = 1'b1;
    while (ready !== 1'b1 && guard < 20) begin
      tick(); guard++;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL abort_start cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    for (int k = 0; k < 37; k++) begin
      if (k == 30) en = 1'b0;
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL abort_ramp cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
    saved = int'(cur_code[7:0]);
    en = 1'b1;
    tick();
    n_checks++;
    if (ready !== 1'b1 || bias_en !== 1'b1) begin
      n_fail++; $display("FAIL abort_no_settle got=%b%b exp=11", ready, bias_en);
    end
    for (int k = 0; k < 30; k++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL abort_reramp cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      c = int'(cur_code[7:0]);
      if (c < lo) lo = c;
    end
    n_checks++;
    if (saved != 7 || lo < saved) begin
      n_fail++; $display("FAIL abort_no_jump got=%0d/%0d exp=7/>=7", saved, lo);
    end
    n_checks++;
    if (c != 10) begin n_fail++; $display("FAIL abort_final got=%0d exp=10", c); end
  endtask

  task automatic test_settle_abort();
    int guard = 0;
    bit rdy_seen = 0;
    en = 1'b0;
    while (bias_en !== 1'b0 && guard < 40) begin tick(); guard++; end
    n_checks++;
    if (dut_vec() !== exp_vec() || bias_en !== 1'b0) begin
      n_fail++; $display("FAIL settle_abort_idle got=%h exp=%h", dut_vec(), exp_vec());
    end
    en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k == 3) en = 1'b0;
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL settle_abort cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
      if (ready === 1'b1) rdy_seen = 1;
      if (k == 3) begin
        n_checks++;
        if (bias_en !== 1'b0) begin
          n_fail++; $display("FAIL settle_abort_bias got=%b exp=0", bias_en);
        end
      end
    end
    n_checks++;
    if (rdy_seen) begin n_fail++; $display("FAIL settle_abort_ready got=1 exp=0"); end
  endtask

  task automatic test_random();
    en = 1'b1;
    for (int k = 0; k < 700; k++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 7) == 0) ch_en = 2'($urandom);
      if ($urandom_range(0, 15) == 0) half_cur = 1'($urandom);
      if ($urandom_range(0, 9) == 0) duty = 8'($urandom);
      if ($urandom_range(0, 19) == 0) cur_tgt = {8'($urandom_range(0, 40)), 8'($urandom_range(0, 40))};
      if (k == 350) begin
        rst = 1'b1;
        #1;
        n_checks++;
        if (dut_vec() !== 20'h0) begin
          n_fail++; $display("FAIL async_reset got=%h exp=%h", dut_vec(), 20'h0);
        end
        model_reset();
        #1 rst = 1'b0;
      end
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_ramp_up();
    test_pwm();
    test_half_cur();
    test_shutdown();
    test_abort();
    test_settle_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irled_drv_ctrl.md
# irled_drv_ctrl

Parametrised digital controller for the IR/RGB LED current-sink drivers on the UltraPlus SoM. It generalises the fixed single-channel IR driver to `NCH` channels. Per channel it provides:
- glitch-free PWM;
- soft-start and soft-stop ramping of the current-trim code;
- a half-current mode.

It also sequences the shared bias enable so that no channel conducts before the bias has settled. The block sits between the register interface and the analog LED driver macros: `bias_en` drives the driver's enable, each `cur_code` slice drives its current trim bits, and each `pwm_out` bit drives its PWM input.

## Interface
Parameters:
- `NCH`, 2: number of LED channels (1–8).
- `PWM_W`, 8: PWM counter width; period is 2^PWM_W cycles.
- `CUR_W`, 8: current-code width per channel.
- `SETTLE_CYC`, 64: bias settle time in cycles (≥1).
- `RAMP_DIV`, 16: cycles per current-code step (≥1).

Ports:
- `clk`  in  1  block clock; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  global driver enable.
- `half_cur`  in  1  when 1, every effective target is halved (target >> 1).
- `ch_en`  in  NCH  per-channel enable.
- `duty`  in  NCH*PWM_W  per-channel PWM duty; channel i occupies bits [i*PWM_W +: PWM_W].
- `cur_tgt`  in  NCH*CUR_W  per-channel target current code; same packing as `duty`.
- `bias_en`  out  1  enable to the analog bias and driver.
- `ready`  out  1  1 while in RUN.
- `pwm_out`  out  NCH  registered PWM drive.
- `cur_code`  out  NCH*CUR_W  registered, ramped current code.

## Operation
Reset values: state OFF, `bias_en`=0, `ready`=0, `pwm_out`=0, every `cur_code` slice=0, and the PWM counter, prescaler and settle counter all 0.

FSM states and transitions:
- **OFF** — `en`=1 → SETTLE.
- **SETTLE** — `bias_en`=1. The settle counter increments each cycle. At count SETTLE_CYC-1 → RUN. `en`=0 → OFF; `bias_en` drops at the same edge.
- **RUN** — `bias_en`=1, `ready`=1. Codes ramp toward their targets and PWM is active. `en`=0 → RAMPDN.
- **RAMPDN** — `bias_en`=1. All effective targets are forced to 0 and `pwm_out` is forced to 0. When every `cur_code` is 0 → OFF. `en`=1 → RUN, with no re-settle.

Ramp:
- The prescaler restarts at 0 on entry to RUN or RAMPDN.
- On a prescaler terminal count (RAMP_DIV-1), each `cur_code[i]` steps by ±1 toward its effective target, and is held when equal.
- Effective target in RUN = `ch_en[i]` ? (`half_cur` ? `cur_tgt[i]`>>1 : `cur_tgt[i]`) : 0.
- Codes never wrap: step +1 only when code < target and -1 only when code > target.

PWM:
- A shared free-running PWM_W-bit counter runs in RUN only and is cleared in all other states.
- `duty_q[i]` is loaded from `duty[i]` when the counter equals 2^PWM_W-1, and also on RUN entry.
- `pwm_out[i]` = RUN & `ch_en[i]` & (counter < `duty_q[i]`), registered.
- `duty`=0 gives constant low. Maximum duty gives (2^PWM_W-1)/2^PWM_W high.
- A mid-period `duty` change takes effect only from the next period.

## Timing
- `en` sampled 1 at edge k in OFF → `bias_en`=1 after edge k.
- `ready`=1 after edge k+SETTLE_CYC.
- First code step occurs at edge (RUN entry)+RAMP_DIV. A code reaches target T at (RUN entry)+T*RAMP_DIV.
- `pwm_out` reflects the counter value with 1 cycle of latency.
- `en`=0 in RUN → `ready`=0 and `pwm_out`=0 one edge later. `bias_en` falls one edge after the last code reaches 0.
- `rst` mid-operation: all outputs return to their reset values immediately (asynchronously).
- `half_cur` or `ch_en` toggling in RUN only changes the target; codes ramp to the new target and never jump.

## Test plan
Bench parameters: NCH=2, PWM_W=4, SETTLE_CYC=8, RAMP_DIV=2.

- **Reset and start-up:** assert `rst`, then `en`=1 → `bias_en`=1 on the next edge, `ready`=1 exactly 8 edges later, all codes 0 during SETTLE.
- **Ramp up:** `cur_tgt`={10,4}, `ch_en`=2'b11 → ch1 reaches 4 at RUN+8 cycles, ch0 reaches 10 at RUN+20, both then hold.
- **PWM:** `duty`={5,0} → ch0 high 5 of every 16 cycles, ch1 constant low. Change ch0 to 12 mid-period → new duty starts at the next counter wrap.
- **Half current:** `half_cur`=1 with ch0 at 10 → ch0 ramps down to 5 in 5 steps (10 cycles), with no overshoot.
- **Shutdown:** `en`=0 with codes {10,4} → `pwm_out`=0 next edge, codes ramp to 0, `bias_en`=0 one edge after ch0 hits 0 (≈20 cycles).
- **Abort and re-enable:** `en`=1 again during RAMPDN → back to RUN with no SETTLE and codes ramp up from their current value. Separately, `en` dropped in SETTLE at cycle 3 → OFF with `bias_en`=0 next edge, `ready` never asserted.
